// File: rtl/cond_logic_pkg.sv
// Shared constants for the condition/flag logic: ARM condition codes,
// NZCV bit positions and FlagW write-select encodings.
package cond_logic_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        FW_NONE = 2'b00,
        FW_CV   = 2'b01,
        FW_NZ   = 2'b10,
        FW_ALL  = 2'b11
    } flagw_e;

endpackage

// File: rtl/cond_logic_cond_check.sv
// Pure combinational ARM condition evaluation of a 4-bit condition field
// against the stored NZCV flags.
module cond_check
    import cond_logic_pkg::*;
#(
    parameter int unsigned COND_W = 4,
    parameter int unsigned FLAG_W = 4
) (
    input  logic [COND_W-1:0] Cond,
    input  logic [FLAG_W-1:0] Flags,
    output logic              CondEx
);

    logic n, z, c, v;
    logic base;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    // Codes come in true/inverted pairs: evaluate the even member, then
    // invert on Cond[0]. NV therefore falls out as the inverse of AL.
    always_comb begin
        base = 1'b0;
        case (Cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = n ~^ v;
            3'b110:  base = ~z & (n ~^ v);
            3'b111:  base = 1'b1;
            default: base = 1'b0;
        endcase
        CondEx = base ^ Cond[0];
    end

endmodule

// File: rtl/cond_logic.sv
// Flag register and write gating for the ARM condition unit.
// Optional macro COND_NOWRITE_EN: suppress RegWrite for compare-type ops.
module cond_logic
    import cond_logic_pkg::*;
#(
    parameter int unsigned FLAG_W = 4,
    parameter int unsigned COND_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COND_W-1:0] Cond,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              NoWrite,
    input  logic              Stall,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              CondEx,
    output logic [FLAG_W-1:0] Flags
);

    logic [1:0] flags_nz;
    logic [1:0] flags_cv;
    logic       wr_en;
    logic       wr_nz;
    logic       wr_cv;

    cond_check #(
        .COND_W (COND_W),
        .FLAG_W (FLAG_W)
    ) u_cond_check (
        .Cond   (Cond),
        .Flags  (Flags),
        .CondEx (CondEx)
    );

    assign wr_en = CondEx & ~Stall;
    assign wr_nz = wr_en & FlagW[1];
    assign wr_cv = wr_en & FlagW[0];

    // An unknown enable fails the if-test, so the half simply holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_nz <= '0;
        end else if (wr_nz) begin
            flags_nz <= ALUFlags[FLAG_N:FLAG_Z];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_cv <= '0;
        end else if (wr_cv) begin
            flags_cv <= ALUFlags[FLAG_C:FLAG_V];
        end
    end

    assign Flags    = {flags_nz, flags_cv};
    assign PCSrc    = PCS  & wr_en;
    assign MemWrite = MemW & wr_en;

`ifdef COND_NOWRITE_EN
    assign RegWrite = RegW & wr_en & ~NoWrite;
`else
    logic unused_nowrite;
    assign unused_nowrite = NoWrite;
    assign RegWrite = RegW & wr_en;
`endif

endmodule
